// File: rtl/rf_bypass_if.sv
// Decode-stage register file bus.
// Read addresses/data, writeback strobe and error flag.
interface rf_bypass_if;
  logic [2:0]  read1_reg;
  logic [2:0]  read2_reg;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        write_en;
  logic [15:0] read1_data;
  logic [15:0] read2_data;
  logic        err;

  modport master (
    output read1_reg,
    output read2_reg,
    output write_reg,
    output write_data,
    output write_en,
    input  read1_data,
    input  read2_data,
    input  err
  );

  modport slave (
    input  read1_reg,
    input  read2_reg,
    input  write_reg,
    input  write_data,
    input  write_en,
    output read1_data,
    output read2_data,
    output err
  );
endinterface

// File: rtl/rf_bypass.sv
// 8x16 register file, two comb read ports, one write port.
// Optional same-cycle writeback-to-read forwarding.
module reg16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_en,
  input  logic [15:0] d,
  output logic [15:0] q
);
  // Recirculating enable register, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 16'h0000;
    end else begin
      q <= w_en ? d : q;
    end
  end
endmodule

module rf_bypass #(
  parameter int NUM_REGS = 8,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  rf_bypass_if.slave  bus
);
  logic [NUM_REGS-1:0] w_en;
  logic [15:0]         regs [NUM_REGS];
  logic [15:0]         stored1;
  logic [15:0]         stored2;
  logic                wr_live;
  logic                fwd1;
  logic                fwd2;

  // A write only lands when reset is low; reset wins.
  assign wr_live = bus.write_en & ~rst;

  // One-hot write decode: one enable per register.
  always_comb begin
    w_en = '0;
    if (wr_live) begin
      w_en[bus.write_reg] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg16 u_reg (
      .clk  (clk),
      .rst  (rst),
      .w_en (w_en[i]),
      .d    (bus.write_data),
      .q    (regs[i])
    );
  end

  // Stored-value read muxes.
  always_comb begin
    stored1 = regs[bus.read1_reg];
    stored2 = regs[bus.read2_reg];
  end

  // Per-port forwarding compare, suppressed under reset.
  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
    if (BYPASS && wr_live) begin
      fwd1 = (bus.write_reg == bus.read1_reg);
      fwd2 = (bus.write_reg == bus.read2_reg);
    end
  end

  // Final read data selection.
  always_comb begin
    bus.read1_data = fwd1 ? bus.write_data : stored1;
    bus.read2_data = fwd2 ? bus.write_data : stored2;
  end

  // Flag a writeback attempted while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err <= bus.write_en;
    end else begin
      bus.err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rf_bypass.sv
// Directed bench for rf_bypass.
// Runs a BYPASS=1 and a BYPASS=0 instance in lockstep.
module tb_rf_bypass;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rf_bypass_if ia ();
  rf_bypass_if ib ();

  assign ib.read1_reg  = ia.read1_reg;
  assign ib.read2_reg  = ia.read2_reg;
  assign ib.write_reg  = ia.write_reg;
  assign ib.write_data = ia.write_data;
  assign ib.write_en   = ia.write_en;

  rf_bypass #(.NUM_REGS(8), .BYPASS(1'b1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  rf_bypass #(.NUM_REGS(8), .BYPASS(1'b0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    ia.write_en   = 1'b1;
    ia.write_reg  = a;
    ia.write_data = d;
    tick();
    ia.write_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.write_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ia.read1_reg = 3'(i);
      ia.read2_reg = 3'(7 - i);
      #1;
      checks++;
      if (ia.read1_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_a_r1[%0d]: got %h exp 0000", i, ia.read1_data);
      end
      checks++;
      if (ia.read2_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_a_r2[%0d]: got %h exp 0000", i, ia.read2_data);
      end
      checks++;
      if (ib.read1_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_b_r1[%0d]: got %h exp 0000", i, ib.read1_data);
      end
    end
    checks++;
    if (ia.err !== 1'b0 || ib.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b/%b exp 0", ia.err, ib.err);
    end
  endtask

  task automatic test_write_readback();
    wr(3'd3, 16'hBEEF);
    wr(3'd7, 16'h1234);
    ia.read1_reg = 3'd3;
    ia.read2_reg = 3'd7;
    #1;
    checks++;
    if (ia.read1_data !== 16'hBEEF || ib.read1_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL wb_r3: got %h/%h exp beef", ia.read1_data, ib.read1_data);
    end
    checks++;
    if (ia.read2_data !== 16'h1234 || ib.read2_data !== 16'h1234) begin
      errors++;
      $display("FAIL wb_r7: got %h/%h exp 1234", ia.read2_data, ib.read2_data);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 7) continue;
      ia.read1_reg = 3'(i);
      ia.read2_reg = 3'(i);
      #1;
      checks++;
      if (ia.read1_data !== 16'h0 || ib.read2_data !== 16'h0) begin
        errors++;
        $display("FAIL wb_other[%0d]: got %h/%h exp 0000",
                 i, ia.read1_data, ib.read2_data);
      end
    end
  endtask

  task automatic test_bypass();
    wr(3'd5, 16'h00AA);
    ia.write_en   = 1'b1;
    ia.write_reg  = 3'd5;
    ia.write_data = 16'h5555;
    ia.read1_reg  = 3'd5;
    ia.read2_reg  = 3'd5;
    #1;
    checks++;
    if (ia.read1_data !== 16'h5555 || ia.read2_data !== 16'h5555) begin
      errors++;
      $display("FAIL byp_on: got %h/%h exp 5555", ia.read1_data, ia.read2_data);
    end
    checks++;
    if (ib.read1_data !== 16'h00AA || ib.read2_data !== 16'h00AA) begin
      errors++;
      $display("FAIL byp_off: got %h/%h exp 00aa", ib.read1_data, ib.read2_data);
    end
    tick();
    ia.write_en = 1'b0;
    #1;
    checks++;
    if (ib.read1_data !== 16'h5555 || ib.read2_data !== 16'h5555) begin
      errors++;
      $display("FAIL byp_off_next: got %h/%h exp 5555",
               ib.read1_data, ib.read2_data);
    end
    checks++;
    if (ia.read1_data !== 16'h5555) begin
      errors++;
      $display("FAIL byp_on_next: got %h exp 5555", ia.read1_data);
    end
  endtask

  task automatic test_no_match();
    wr(3'd1, 16'h0101);
    wr(3'd6, 16'h0606);
    ia.write_en   = 1'b1;
    ia.write_reg  = 3'd2;
    ia.write_data = 16'hFFFF;
    ia.read1_reg  = 3'd1;
    ia.read2_reg  = 3'd6;
    #1;
    checks++;
    if (ia.read1_data !== 16'h0101 || ia.read2_data !== 16'h0606) begin
      errors++;
      $display("FAIL nomatch_a: got %h/%h exp 0101/0606",
               ia.read1_data, ia.read2_data);
    end
    checks++;
    if (ib.read1_data !== 16'h0101 || ib.read2_data !== 16'h0606) begin
      errors++;
      $display("FAIL nomatch_b: got %h/%h exp 0101/0606",
               ib.read1_data, ib.read2_data);
    end
    tick();
    ia.write_en  = 1'b0;
    ia.read1_reg = 3'd2;
    #1;
    checks++;
    if (ia.read1_data !== 16'hFFFF || ib.read1_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL nomatch_r2: got %h/%h exp ffff",
               ia.read1_data, ib.read1_data);
    end
  endtask

  task automatic test_reset_vs_write();
    wr(3'd4, 16'h7777);
    rst           = 1'b1;
    ia.write_en   = 1'b1;
    ia.write_reg  = 3'd4;
    ia.write_data = 16'h9999;
    ia.read1_reg  = 3'd4;
    ia.read2_reg  = 3'd4;
    #1;
    checks++;
    if (ia.read1_data !== 16'h7777 || ia.read2_data !== 16'h7777) begin
      errors++;
      $display("FAIL rst_nobyp: got %h/%h exp 7777",
               ia.read1_data, ia.read2_data);
    end
    tick();
    rst         = 1'b0;
    ia.write_en = 1'b0;
    #1;
    checks++;
    if (ia.read1_data !== 16'h0000 || ib.read1_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_r4: got %h/%h exp 0000", ia.read1_data, ib.read1_data);
    end
    checks++;
    if (ia.err !== 1'b1 || ib.err !== 1'b1) begin
      errors++;
      $display("FAIL rst_err_set: got %b/%b exp 1", ia.err, ib.err);
    end
    for (int i = 0; i < 8; i++) begin
      ia.read2_reg = 3'(i);
      #1;
      checks++;
      if (ia.read2_data !== 16'h0000) begin
        errors++;
        $display("FAIL rst_clear[%0d]: got %h exp 0000", i, ia.read2_data);
      end
    end
    tick();
    checks++;
    if (ia.err !== 1'b0 || ib.err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err_clr: got %b/%b exp 0", ia.err, ib.err);
    end
  endtask

  task automatic test_walk_all();
    logic [15:0] e1;
    logic [15:0] e2;
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 16'(i * 16'h1111));
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        ia.read1_reg = 3'(i);
        ia.read2_reg = 3'(j);
        e1 = 16'(i * 16'h1111);
        e2 = 16'(j * 16'h1111);
        #1;
        checks++;
        if (ia.read1_data !== e1 || ib.read1_data !== e1) begin
          errors++;
          $display("FAIL walk_r1[%0d,%0d]: got %h/%h exp %h",
                   i, j, ia.read1_data, ib.read1_data, e1);
        end
        checks++;
        if (ia.read2_data !== e2 || ib.read2_data !== e2) begin
          errors++;
          $display("FAIL walk_r2[%0d,%0d]: got %h/%h exp %h",
                   i, j, ia.read2_data, ib.read2_data, e2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    ia.write_en   = 1'b1;
    ia.write_reg  = 3'd0;
    ia.write_data = 16'hABCD;
    ia.read1_reg  = 3'd0;
    ia.read2_reg  = 3'd1;
    #1;
    checks++;
    if (ia.read1_data !== 16'hABCD || ia.read2_data !== 16'h1111) begin
      errors++;
      $display("FAIL b2b_a: got %h/%h exp abcd/1111",
               ia.read1_data, ia.read2_data);
    end
    checks++;
    if (ib.read1_data !== 16'h0000 || ib.read2_data !== 16'h1111) begin
      errors++;
      $display("FAIL b2b_b: got %h/%h exp 0000/1111",
               ib.read1_data, ib.read2_data);
    end
    tick();
    ia.write_reg  = 3'd1;
    ia.write_data = 16'h4321;
    #1;
    checks++;
    if (ia.read1_data !== 16'hABCD || ia.read2_data !== 16'h4321) begin
      errors++;
      $display("FAIL b2b_a2: got %h/%h exp abcd/4321",
               ia.read1_data, ia.read2_data);
    end
    checks++;
    if (ib.read1_data !== 16'hABCD || ib.read2_data !== 16'h1111) begin
      errors++;
      $display("FAIL b2b_b2: got %h/%h exp abcd/1111",
               ib.read1_data, ib.read2_data);
    end
    tick();
    ia.write_en = 1'b0;
    #1;
    checks++;
    if (ib.read2_data !== 16'h4321 || ia.err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got %h err %b exp 4321 err 0",
               ib.read2_data, ia.err);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    ia.read1_reg  = 3'd0;
    ia.read2_reg  = 3'd0;
    ia.write_reg  = 3'd0;
    ia.write_data = 16'h0000;
    ia.write_en   = 1'b0;
    test_reset();
    test_write_readback();
    test_bypass();
    test_no_match();
    test_reset_vs_write();
    test_walk_all();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
